// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: computes A + B + Cin one bit per clock, LSB first, through a
// single full-adder cell with a registered carry; start/done handshake to the ALU FSM.
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_s;
  logic             carry_r;
  logic             carry_s;
  logic             sum_bit_s;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder cell, next partial result and next-state decode
  always_comb begin
    sum_bit_s = a_r[0] ^ b_r[0] ^ carry_r;
    carry_s   = maj3(a_r[0], b_r[0], carry_r);
    // New sum bit enters at the MSB so the LSB-first stream lands in order.
    res_s     = {sum_bit_s, res_r[WIDTH-1:1]};
    state_s   = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (count_r == LAST) state_s = DONE;
        else                 state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand capture, serial shifting, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= Cin;
            count_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          res_r   <= res_s;
          carry_r <= carry_s;
          if (count_r != LAST) count_r <= count_r + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake flags and result/status outputs; results move only on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
      if ((state_r == RUN) && (count_r == LAST)) begin
        sum_r  <= res_s;
        cout_r <= carry_s;
        ovf_r  <= carry_r ^ carry_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign Sum      = sum_r;
  assign Cout     = cout_r;
  assign Overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Scoreboard bench for serial_adder_8bit: driver pushes reference results computed
// with plain integer arithmetic; a monitor pops and compares on every done pulse.
module tb_serial_adder_8bit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  logic [7:0] held_sum = 8'h00;
  logic       held_cout = 1'b0;
  logic       held_ovf = 1'b0;

  serial_adder_8bit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer sum for carry, signed integer range for overflow
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input int when);
    exp_t e;
    int   u;
    int   s;
    u = int'(a) + int'(b) + int'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.sum  = u[7:0];
    e.cout = (u > 255);
    e.ovf  = (s > 127) || (s < -128);
    e.cyc  = when;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      held_sum  = 8'h00;
      held_cout = 1'b0;
      held_ovf  = 1'b0;
      q.delete();
    end else begin
      if (busy && done) chk("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", 32'(Sum), 32'(e.sum));
          chk("cout", 32'(Cout), 32'(e.cout));
          chk("overflow", 32'(Overflow), 32'(e.ovf));
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
          held_sum  = e.sum;
          held_cout = e.cout;
          held_ovf  = e.ovf;
        end
        busy_cnt = 0;
      end else begin
        chk("sum_hold", 32'(Sum), 32'(held_sum));
        chk("cout_hold", 32'(Cout), 32'(held_cout));
        chk("ovf_hold", 32'(Overflow), 32'(held_ovf));
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    q.push_back(model(a, b, cin, cyc + WIDTH + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s pending=%0d expected=0", name, q.size());
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    issue(a, b, cin);
    wait_idle("op");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(Sum), 32'd0);
    chk("reset_cout", 32'(Cout), 32'd0);
    chk("reset_ovf", 32'(Overflow), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h0F, 8'hF0, 1'b1);

    // Subtract via inversion, with an ignored start and operand change mid-RUN
    issue(8'h10, 8'hFE, 1'b1);
    repeat (2) @(negedge clk);
    A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignored_start");
    repeat (5) @(negedge clk);

    // start held high: one acceptance every WIDTH+2 cycles
    @(negedge clk);
    A = 8'h3C; B = 8'h5A; Cin = 1'b1; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i % (WIDTH + 2) == 0) q.push_back(model(8'h3C, 8'h5A, 1'b1, cyc + WIDTH + 1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle("back_to_back");

    // Asynchronous abort at count=4
    issue(8'hAA, 8'h33, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    chk("abort_ovf", 32'(Overflow), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(8'h22, 8'h11, 1'b0);

    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
